fwd_scoreboard: RTL and testbench
=================================

Name: fwd_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the in-order RISC-V pipeline.
- Keeps an internal shift register ("slots") of in-flight writers past EX, so the block does not rely on individual EX/MEM and MEM/WB port pairs.
- Per read port, produces EX-stage and ID-stage (branch) forwarding selects, a load-use/branch stall request, and a store-data (mem-to-mem) bypass.
- Counts stall cycles.

Parameters:
- NUM_RD_PORTS, 2, number of source-register read ports per consumer (rs1, rs2, ...)
- FWD_DEPTH, 2, tracked slots past EX; slot 0 = EX/MEM, slot FWD_DEPTH-1 = final stage before regfile write
- REG_AW, 5, register address width
- LOAD_LAT, 1, load result is usable once the load occupies slot >= LOAD_LAT; range 0..FWD_DEPTH-1
- SEL_W, $clog2(FWD_DEPTH+1), forward-select width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- hold_i  in  1  global pipeline freeze; slots keep their contents
- flush_i  in  1  issue this cycle is treated as invalid
- iss_valid_i  in  1  instruction in ID/EX is valid and writes a register
- iss_rd_i  in  REG_AW  destination of the ID/EX instruction
- iss_is_load_i  in  1  ID/EX instruction is a load
- ex_rs_i  in  NUM_RD_PORTS*REG_AW  sources of the ID/EX instruction
- ex_rs_use_i  in  NUM_RD_PORTS  per-port source used (e.g. rs2 is not used by OP-IMM)
- id_rs_i  in  NUM_RD_PORTS*REG_AW  sources of the IF/ID instruction
- id_rs_use_i  in  NUM_RD_PORTS  per-port use flags for IF/ID
- id_branch_i  in  1  IF/ID instruction resolves in ID (branch)
- mem_store_i  in  1  store in the EX/MEM stage
- mem_store_rs2_i  in  REG_AW  store-data source register
- ex_fwd_sel_o  out  NUM_RD_PORTS*SEL_W  0 = regfile, k+1 = slot k
- id_fwd_sel_o  out  NUM_RD_PORTS*SEL_W  branch operand select, same encoding
- mem_fwd_sel_o  out  SEL_W  store-data select from slots 1..FWD_DEPTH-1
- stall_o  out  1  hold IF/ID and insert a bubble into ID/EX
- stall_cnt_o  out  32  saturating count of stall cycles

Behaviour:
- Slot entry: {valid, rd, is_load}.
- Reset (asynchronous): all slots invalid; stall_cnt_o = 0. All select outputs therefore read 0 and stall_o reads 0.
- Each clk edge with hold_i=0:
  - slot[k] <= slot[k-1];
  - slot[0] <= {iss_valid_i & ~flush_i & (iss_rd_i!=0), iss_rd_i, iss_is_load_i};
  - the oldest slot retires.
- hold_i=1: slots are unchanged and stall_cnt_o does not increment.
- A slot "matches" register r when valid and rd==r; r==0 never matches.
- Priority: the lowest index (youngest) matching slot wins.
- ex_fwd_sel[p] (combinational): k+1 of the youngest matching slot for ex_rs[p], if ex_rs_use[p]=1; otherwise 0.
- id_fwd_sel[p]: computed only when id_branch_i=1; otherwise 0. k+1 of the youngest matching slot.
- Stall conditions (OR over ports with id_rs_use[p]=1):
  - Non-branch ID consumer:
    - matches the ID/EX producer (iss_valid_i, !flush_i) that is a load, and LOAD_LAT>0;
    - or the youngest matching slot k is a load with k+1 < LOAD_LAT.
  - Branch ID consumer:
    - matches the ID/EX producer (any kind);
    - or the youngest matching slot k is a load with k < LOAD_LAT.
  - A younger non-load match shadows an older load (no stall).
  - stall_o is combinational. While stall_o=1, id_fwd_sel_o is still driven but is ignored by the top level.
- mem_fwd_sel_o: when mem_store_i=1, k+1 of the youngest matching slot k>=1 (older than the store) for mem_store_rs2_i; otherwise 0. Slot 0 is the store itself and never matches for this output.
- stall_cnt_o: increments on each edge with stall_o=1 & hold_i=0; saturates at 0xFFFFFFFF.
- Simultaneous flush_i and stall_o: flush wins at the top level. The block still reports stall_o; the issue is invalidated.
- Reset mid-stall: outputs drop to 0 immediately (asynchronous).

Decomposition:
- Shared package fwd_pkg:
  - typedef slot_t {valid, rd, is_load};
  - constants FWD_NONE=0, REG_X0=0.
- One sub-module, fwd_match: priority search over the slots for one register. Outputs hit, slot index and is_load. Instantiated per ex, id and mem query.

Test Plan:
1. Reset asserted with slots populated -> all selects 0, stall_o=0, stall_cnt_o=0 asynchronously, before any clock edge.
2. Issue add x5 (non-load); next cycle ex_rs[0]=5 -> ex_fwd_sel[0]=1. One cycle later -> 2. One cycle after that -> 0 (retired).
3. Issue lw x7, then ID consumer rs1=7 (non-branch), LOAD_LAT=1 -> stall_o=1 for exactly 1 cycle, stall_cnt_o=1. After the bubble, ex_fwd_sel[0]=2.
4. Issue add x3; branch in ID reading x3 -> stall 1 cycle. Then id_fwd_sel[0]=1.
5. Slot0=add x4 and slot1=lw x4; branch reads x4 -> no stall, id_fwd_sel=1 (youngest wins). Separately, x0 writes never forward.
6. lw x9 in slot1, sw with rs2=9 in EX/MEM (mem_store_i=1) -> mem_fwd_sel_o=2. With hold_i=1 for 3 cycles, selects are frozen and stall_cnt_o is unchanged.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding scoreboard.
// slot_t.rd is sized for the widest register address any instance may use.
package fwd_pkg;
   localparam int REG_AW_MAX = 8;
   localparam int FWD_NONE   = 0;
   localparam int REG_X0     = 0;

   typedef struct packed {
      logic                  valid;
      logic [REG_AW_MAX-1:0] rd;
      logic                  is_load;
   } slot_t;
endpackage

// File: rtl/fwd_match.sv
// Priority search of the in-flight slots for one source register.
// The youngest (lowest index) valid writer at or above MIN_SLOT wins.
module fwd_match
   import fwd_pkg::*;
#(
   parameter int FWD_DEPTH = 2,
   parameter int REG_AW    = 5,
   parameter int MIN_SLOT  = 0,
   parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
   input  slot_t [FWD_DEPTH-1:0] slots_i,
   input  logic                  en_i,
   input  logic [REG_AW-1:0]     reg_i,
   output logic                  hit_o,
   output logic [SEL_W-1:0]      idx_o,
   output logic                  is_load_o
);

   always_comb begin
      hit_o     = 1'b0;
      idx_o     = '0;
      is_load_o = 1'b0;
      if (en_i && (reg_i != REG_AW'(REG_X0))) begin
         // Walk oldest to youngest so the youngest match overwrites.
         for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if ((k >= MIN_SLOT) && slots_i[k].valid &&
                (slots_i[k].rd == REG_AW_MAX'(reg_i))) begin
               hit_o     = 1'b1;
               idx_o     = SEL_W'(k);
               is_load_o = slots_i[k].is_load;
            end
         end
      end
   end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding and hazard unit: tracks writers past EX in a shift register and
// derives EX/ID/store-data forwarding selects, the load-use stall and a stall counter.
module fwd_scoreboard
   import fwd_pkg::*;
#(
   parameter int NUM_RD_PORTS = 2,
   parameter int FWD_DEPTH    = 2,
   parameter int REG_AW       = 5,
   parameter int LOAD_LAT     = 1,
   parameter int SEL_W        = $clog2(FWD_DEPTH + 1)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           hold_i,
   input  logic                           flush_i,
   input  logic                           iss_valid_i,
   input  logic [REG_AW-1:0]              iss_rd_i,
   input  logic                           iss_is_load_i,
   input  logic [NUM_RD_PORTS*REG_AW-1:0] ex_rs_i,
   input  logic [NUM_RD_PORTS-1:0]        ex_rs_use_i,
   input  logic [NUM_RD_PORTS*REG_AW-1:0] id_rs_i,
   input  logic [NUM_RD_PORTS-1:0]        id_rs_use_i,
   input  logic                           id_branch_i,
   input  logic                           mem_store_i,
   input  logic [REG_AW-1:0]              mem_store_rs2_i,
   output logic [NUM_RD_PORTS*SEL_W-1:0]  ex_fwd_sel_o,
   output logic [NUM_RD_PORTS*SEL_W-1:0]  id_fwd_sel_o,
   output logic [SEL_W-1:0]               mem_fwd_sel_o,
   output logic                           stall_o,
   output logic [31:0]                    stall_cnt_o
);

   slot_t [FWD_DEPTH-1:0]   slot_q, slot_d;
   logic  [31:0]            stall_cnt_q, stall_cnt_d;
   logic  [NUM_RD_PORTS-1:0] stall_p;
   logic                    stall_raw;

   always_comb begin
      slot_d = slot_q;
      if (!hold_i) begin
         for (int k = FWD_DEPTH - 1; k > 0; k--) begin
            slot_d[k] = slot_q[k-1];
         end
         slot_d[0].valid   = iss_valid_i & ~flush_i & (iss_rd_i != REG_AW'(REG_X0));
         slot_d[0].rd      = REG_AW_MAX'(iss_rd_i);
         slot_d[0].is_load = iss_is_load_i;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_o && !hold_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q      <= '0;
         stall_cnt_q <= '0;
      end else begin
         slot_q      <= slot_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
      logic              ex_hit, id_hit, id_ld, iss_match;
      logic              ex_ld_unused;
      logic [SEL_W-1:0]  ex_idx, id_idx;
      logic [REG_AW-1:0] id_r;

      assign id_r = id_rs_i[p*REG_AW +: REG_AW];

      fwd_match #(.FWD_DEPTH(FWD_DEPTH), .REG_AW(REG_AW), .MIN_SLOT(0), .SEL_W(SEL_W)) u_ex (
         .slots_i   (slot_q),
         .en_i      (ex_rs_use_i[p]),
         .reg_i     (ex_rs_i[p*REG_AW +: REG_AW]),
         .hit_o     (ex_hit),
         .idx_o     (ex_idx),
         .is_load_o (ex_ld_unused)
      );

      fwd_match #(.FWD_DEPTH(FWD_DEPTH), .REG_AW(REG_AW), .MIN_SLOT(0), .SEL_W(SEL_W)) u_id (
         .slots_i   (slot_q),
         .en_i      (1'b1),
         .reg_i     (id_r),
         .hit_o     (id_hit),
         .idx_o     (id_idx),
         .is_load_o (id_ld)
      );

      assign iss_match = iss_valid_i & ~flush_i & (iss_rd_i == id_r) &
                         (id_r != REG_AW'(REG_X0));

      // The ID/EX producer becomes slot 0 next cycle, so it shadows every slot match.
      assign stall_p[p] = id_rs_use_i[p] &
         (iss_match ? (id_branch_i | (iss_is_load_i & (LOAD_LAT > 0)))
                    : (id_hit & id_ld & (id_branch_i ? (int'(id_idx) < LOAD_LAT)
                                                     : (int'(id_idx) + 1 < LOAD_LAT))));

      assign ex_fwd_sel_o[p*SEL_W +: SEL_W] = ex_hit ? (ex_idx + SEL_W'(1)) : SEL_W'(FWD_NONE);
      assign id_fwd_sel_o[p*SEL_W +: SEL_W] = (id_branch_i && id_hit) ? (id_idx + SEL_W'(1))
                                                                      : SEL_W'(FWD_NONE);
   end

   logic             mem_hit, mem_ld_unused;
   logic [SEL_W-1:0] mem_idx;

   fwd_match #(.FWD_DEPTH(FWD_DEPTH), .REG_AW(REG_AW), .MIN_SLOT(1), .SEL_W(SEL_W)) u_mem (
      .slots_i   (slot_q),
      .en_i      (mem_store_i),
      .reg_i     (mem_store_rs2_i),
      .hit_o     (mem_hit),
      .idx_o     (mem_idx),
      .is_load_o (mem_ld_unused)
   );

   assign mem_fwd_sel_o = mem_hit ? (mem_idx + SEL_W'(1)) : SEL_W'(FWD_NONE);

   // Gate by rst so an issue-side hazard cannot hold stall high during reset.
   assign stall_raw   = |stall_p;
   assign stall_o     = stall_raw & ~rst;
   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed test-plan scenarios followed by randomized traffic, all checked
// against a queue-based reference model of the in-flight writers.
module tb_fwd_scoreboard;
   localparam int NP = 2;
   localparam int D  = 2;
   localparam int AW = 5;
   localparam int LL = 1;
   localparam int SW = $clog2(D + 1);

   logic            clk = 1'b0;
   logic            rst;
   logic            hold, flush, iss_valid, iss_ld, id_br, mem_st;
   logic [AW-1:0]   iss_rd, mem_rs2;
   logic [NP*AW-1:0] ex_rs, id_rs;
   logic [NP-1:0]   ex_use, id_use;
   logic [NP*SW-1:0] ex_sel, id_sel;
   logic [SW-1:0]   mem_sel;
   logic            stall;
   logic [31:0]     stall_cnt;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {bit v; int rd; bit ld;} ms_t;
   ms_t         mq[$];
   bit [31:0]   m_cnt;
   bit          e_stall;

   always #5 clk = ~clk;

   fwd_scoreboard #(.NUM_RD_PORTS(NP), .FWD_DEPTH(D), .REG_AW(AW), .LOAD_LAT(LL)) dut (
      .clk             (clk),
      .rst             (rst),
      .hold_i          (hold),
      .flush_i         (flush),
      .iss_valid_i     (iss_valid),
      .iss_rd_i        (iss_rd),
      .iss_is_load_i   (iss_ld),
      .ex_rs_i         (ex_rs),
      .ex_rs_use_i     (ex_use),
      .id_rs_i         (id_rs),
      .id_rs_use_i     (id_use),
      .id_branch_i     (id_br),
      .mem_store_i     (mem_st),
      .mem_store_rs2_i (mem_rs2),
      .ex_fwd_sel_o    (ex_sel),
      .id_fwd_sel_o    (id_sel),
      .mem_fwd_sel_o   (mem_sel),
      .stall_o         (stall),
      .stall_cnt_o     (stall_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int youngest(int r, int lo);
      if (r == 0) return -1;
      for (int k = lo; k < mq.size(); k++)
         if (mq[k].v && mq[k].rd == r) return k;
      return -1;
   endfunction

   function automatic bit model_stall();
      bit s = 0;
      for (int p = 0; p < NP; p++) begin
         int r = int'(id_rs[p*AW +: AW]);
         int k;
         if (!id_use[p] || r == 0) continue;
         if (iss_valid && !flush && int'(iss_rd) == r) begin
            if (id_br || (iss_ld && LL > 0)) s = 1;
         end else begin
            k = youngest(r, 0);
            if (k >= 0 && mq[k].ld && (id_br ? (k < LL) : (k + 1 < LL))) s = 1;
         end
      end
      return s;
   endfunction

   task automatic model_reset();
      mq.delete();
      for (int k = 0; k < D; k++) mq.push_back('{v: 0, rd: 0, ld: 0});
      m_cnt = 0;
   endtask

   task automatic idle();
      hold = 0; flush = 0; iss_valid = 0; iss_rd = '0; iss_ld = 0;
      ex_rs = '0; ex_use = '0; id_rs = '0; id_use = '0; id_br = 0;
      mem_st = 0; mem_rs2 = '0;
   endtask

   task automatic settle();
      logic [NP*SW-1:0] e_ex, e_id;
      logic [SW-1:0]    e_mem;
      int k;
      #1;
      e_ex = '0; e_id = '0; e_mem = '0;
      for (int p = 0; p < NP; p++) begin
         k = youngest(int'(ex_rs[p*AW +: AW]), 0);
         if (ex_use[p] && k >= 0) e_ex[p*SW +: SW] = SW'(k + 1);
         k = youngest(int'(id_rs[p*AW +: AW]), 0);
         if (id_br && k >= 0) e_id[p*SW +: SW] = SW'(k + 1);
      end
      k = youngest(int'(mem_rs2), 1);
      if (mem_st && k >= 0) e_mem = SW'(k + 1);
      e_stall = model_stall();
      chk("ex_sel", 64'(ex_sel), 64'(e_ex));
      chk("id_sel", 64'(id_sel), 64'(e_id));
      chk("mem_sel", 64'(mem_sel), 64'(e_mem));
      chk("stall", 64'(stall), 64'(e_stall));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
   endtask

   task automatic tick();
      @(posedge clk);
      if (!hold) begin
         mq.push_front('{v: iss_valid && !flush && iss_rd != 0, rd: int'(iss_rd), ld: iss_ld});
         void'(mq.pop_back());
         if (e_stall && m_cnt != 32'hFFFF_FFFF) m_cnt++;
      end
      @(negedge clk);
   endtask

   task automatic issue(input int rd, input bit ld);
      idle(); iss_valid = 1; iss_rd = AW'(rd); iss_ld = ld;
   endtask

   bit [31:0] cnt_saved;

   initial begin
      idle();
      rst = 1;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 0;
      settle();

      // Reset with populated slots and a pending load-use hazard.
      issue(7, 1); settle(); tick();
      issue(7, 1); id_rs[AW-1:0] = 7; id_use = 2'b01; ex_rs[AW-1:0] = 7; ex_use = 2'b01;
      settle();
      chk("pre_rst_stall", 64'(stall), 64'd1);
      rst = 1; #1;
      chk("rst_ex_sel", 64'(ex_sel), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_cnt", 64'(stall_cnt), 64'd0);
      chk("rst_mem", 64'(mem_sel), 64'd0);
      rst = 0;
      model_reset();
      idle();
      @(negedge clk);

      // add x5 ages through slots then retires
      issue(5, 0); settle(); tick();
      idle(); ex_rs[AW-1:0] = 5; ex_use = 2'b01;
      settle(); chk("t2_age0", 64'(ex_sel[SW-1:0]), 64'd1); tick();
      settle(); chk("t2_age1", 64'(ex_sel[SW-1:0]), 64'd2); tick();
      settle(); chk("t2_retired", 64'(ex_sel[SW-1:0]), 64'd0); tick();

      // lw x7 followed by dependent consumer: one bubble
      issue(7, 1); id_rs[AW-1:0] = 7; id_use = 2'b01;
      settle(); chk("t3_stall", 64'(stall), 64'd1); tick();
      idle(); id_rs[AW-1:0] = 7; id_use = 2'b01;
      settle(); chk("t3_nostall", 64'(stall), 64'd0);
      chk("t3_cnt", 64'(stall_cnt), 64'd1); tick();
      idle(); ex_rs[AW-1:0] = 7; ex_use = 2'b01;
      settle(); chk("t3_fwd", 64'(ex_sel[SW-1:0]), 64'd2); tick();

      // branch on freshly computed x3
      issue(3, 0); id_rs[AW-1:0] = 3; id_use = 2'b01; id_br = 1;
      settle(); chk("t4_stall", 64'(stall), 64'd1); tick();
      idle(); id_rs[AW-1:0] = 3; id_use = 2'b01; id_br = 1;
      settle(); chk("t4_id_sel", 64'(id_sel[SW-1:0]), 64'd1);
      chk("t4_nostall", 64'(stall), 64'd0); tick();

      // younger add shadows older load; x0 never forwards
      issue(4, 1); settle(); tick();
      issue(4, 0); settle(); tick();
      idle(); id_rs[AW-1:0] = 4; id_use = 2'b01; id_br = 1;
      settle(); chk("t5_nostall", 64'(stall), 64'd0);
      chk("t5_id_sel", 64'(id_sel[SW-1:0]), 64'd1); tick();
      issue(0, 1); settle(); tick();
      idle(); ex_rs = '0; ex_use = 2'b11; iss_valid = 1; iss_ld = 1; id_use = 2'b11;
      settle(); chk("t5_x0_sel", 64'(ex_sel), 64'd0);
      chk("t5_x0_stall", 64'(stall), 64'd0); tick();

      // store-data bypass from load in slot1, then freeze under hold
      issue(9, 1); settle(); tick();
      idle(); settle(); tick();
      idle(); mem_st = 1; mem_rs2 = 9;
      settle(); chk("t6_mem", 64'(mem_sel), 64'd2);
      cnt_saved = stall_cnt;
      hold = 1; iss_valid = 1; iss_rd = 11; iss_ld = 1; id_rs[AW-1:0] = 11; id_use = 2'b01;
      repeat (3) begin
         settle(); tick();
      end
      settle();
      chk("t6_mem_hold", 64'(mem_sel), 64'd2);
      chk("t6_stall_hold", 64'(stall), 64'd1);
      chk("t6_cnt_hold", 64'(stall_cnt), 64'(cnt_saved));
      tick();

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         hold      = ($urandom % 8) == 0;
         flush     = ($urandom % 6) == 0;
         iss_valid = ($urandom % 4) != 0;
         iss_rd    = AW'($urandom_range(0, 7));
         iss_ld    = $urandom % 2;
         for (int p = 0; p < NP; p++) begin
            ex_rs[p*AW +: AW] = AW'($urandom_range(0, 7));
            id_rs[p*AW +: AW] = AW'($urandom_range(0, 7));
         end
         ex_use  = NP'($urandom);
         id_use  = NP'($urandom);
         id_br   = ($urandom % 3) == 0;
         mem_st  = $urandom % 2;
         mem_rs2 = AW'($urandom_range(0, 7));
         settle();
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
